// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign-corrected in a two-cycle FIX phase.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy,
  output logic                  done,
  output logic                  stall,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int N  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] count_one  = CW'(1);
  localparam logic [CW-1:0] count_full = CW'(N);
  localparam logic [5:0] f_mult  = 6'b011000;
  localparam logic [5:0] f_multu = 6'b011001;
  localparam logic [5:0] f_div   = 6'b011010;
  localparam logic [5:0] f_divu  = 6'b011011;
  localparam logic [5:0] f_mfhi  = 6'b010000;
  localparam logic [5:0] f_mthi  = 6'b010001;
  localparam logic [5:0] f_mflo  = 6'b010010;
  localparam logic [5:0] f_mtlo  = 6'b010011;

  typedef enum logic [1:0] {
    st_idle = 2'd0,
    st_calc = 2'd1,
    st_fix  = 2'd2,
    st_done = 2'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   count_r;
  logic            fix_phase_r, is_mul_r, neg_lo_r, neg_hi_r;
  logic [N-1:0]    wa_r, wb_r, opd_r, orig_rs_r, hi_r, lo_r;
  logic            busy_r, done_r, dbz_r;
  logic            busy_next_s, done_next_s;
  logic            is_md_s, is_sup_s, op_mul_s, op_signed_s, can_accept_s;
  logic [N-1:0]    rs_abs_s, rt_abs_s, div_diff_s;
  logic [N:0]      mul_sum_s, div_shift_s;
  logic            div_ge_s;
  logic [2*N-1:0]  prod_neg_s;

  // Function-code decode.
  always_comb begin
    is_md_s     = 1'b0;
    is_sup_s    = 1'b1;
    op_mul_s    = 1'b0;
    op_signed_s = 1'b0;
    case (funct)
      f_mult:  begin is_md_s = 1'b1; op_mul_s = 1'b1; op_signed_s = 1'b1; end
      f_multu: begin is_md_s = 1'b1; op_mul_s = 1'b1; end
      f_div:   begin is_md_s = 1'b1; op_signed_s = 1'b1; end
      f_divu:  is_md_s = 1'b1;
      f_mfhi, f_mthi, f_mflo, f_mtlo: is_sup_s = 1'b1;
      default: is_sup_s = 1'b0;
    endcase
  end

  // Operand magnitudes and per-step arithmetic; MIN's magnitude is correct as unsigned.
  always_comb begin
    rs_abs_s     = (op_signed_s && rs_data[N-1]) ? -rs_data : rs_data;
    rt_abs_s     = (op_signed_s && rt_data[N-1]) ? -rt_data : rt_data;
    mul_sum_s    = {1'b0, wa_r} + (wb_r[0] ? {1'b0, opd_r} : {(N+1){1'b0}});
    div_shift_s  = {wa_r, wb_r[N-1]};
    div_ge_s     = (div_shift_s >= {1'b0, opd_r});
    div_diff_s   = div_shift_s[N-1:0] - opd_r;
    prod_neg_s   = -{wa_r, wb_r};
    can_accept_s = (state_r == st_idle) || (state_r == st_done);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= st_idle;
    else       state_r <= state_next_s;
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      st_idle, st_done: begin
        if (start && is_md_s) state_next_s = st_calc;
        else                  state_next_s = st_idle;
      end
      st_calc: begin
        if (count_r == count_one) state_next_s = st_fix;
        else                      state_next_s = st_calc;
      end
      st_fix: begin
        if (fix_phase_r) state_next_s = st_done;
        else             state_next_s = st_fix;
      end
      default: state_next_s = st_idle;
    endcase
  end

  // Status decode of the upcoming state, registered below.
  always_comb begin
    busy_next_s = (state_next_s == st_calc) || (state_next_s == st_fix);
    done_next_s = (state_next_s == st_done);
  end

  // Datapath: operand capture, iteration, sign fix-up and HI/LO writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};  fix_phase_r <= 1'b0;  is_mul_r <= 1'b0;
      neg_lo_r <= 1'b0;       neg_hi_r <= 1'b0;
      wa_r <= {N{1'b0}};      wb_r <= {N{1'b0}};    opd_r <= {N{1'b0}};
      orig_rs_r <= {N{1'b0}}; hi_r <= {N{1'b0}};    lo_r <= {N{1'b0}};
      busy_r <= 1'b0;         done_r <= 1'b0;       dbz_r <= 1'b0;
    end else begin
      busy_r <= busy_next_s;
      done_r <= done_next_s;
      case (state_r)
        st_idle, st_done: begin
          if (start && is_md_s) begin
            is_mul_r    <= op_mul_s;
            wa_r        <= {N{1'b0}};
            wb_r        <= op_mul_s ? rt_abs_s : rs_abs_s;
            opd_r       <= op_mul_s ? rs_abs_s : rt_abs_s;
            orig_rs_r   <= rs_data;
            neg_lo_r    <= op_signed_s & (rs_data[N-1] ^ rt_data[N-1]);
            neg_hi_r    <= op_signed_s & rs_data[N-1];
            dbz_r       <= ~op_mul_s & (rt_data == {N{1'b0}});
            count_r     <= count_full;
            fix_phase_r <= 1'b0;
          end else if (start && (funct == f_mthi)) begin
            hi_r <= rs_data;
          end else if (start && (funct == f_mtlo)) begin
            lo_r <= rs_data;
          end
        end
        st_calc: begin
          count_r <= count_r - count_one;
          if (is_mul_r) begin
            wa_r <= mul_sum_s[N:1];
            wb_r <= {mul_sum_s[0], wb_r[N-1:1]};
          end else if (div_ge_s) begin
            wa_r <= div_diff_s;
            wb_r <= {wb_r[N-2:0], 1'b1};
          end else begin
            wa_r <= div_shift_s[N-1:0];
            wb_r <= {wb_r[N-2:0], 1'b0};
          end
        end
        st_fix: begin
          if (!fix_phase_r) begin
            fix_phase_r <= 1'b1;
            if (is_mul_r) begin
              if (neg_lo_r) {wa_r, wb_r} <= prod_neg_s;
            end else begin
              if (neg_lo_r) wb_r <= -wb_r;
              if (neg_hi_r) wa_r <= -wa_r;
            end
          end else begin
            fix_phase_r <= 1'b0;
            // Divide by zero reports the untouched dividend rather than the iterated remainder.
            if (dbz_r) begin
              hi_r <= orig_rs_r;
              lo_r <= {N{1'b1}};
            end else begin
              hi_r <= wa_r;
              lo_r <= wb_r;
            end
          end
        end
        default: fix_phase_r <= 1'b0;
      endcase
    end
  end

  // Move-from read port.
  always_comb begin
    if (funct == f_mfhi)      result = hi_r;
    else if (funct == f_mflo) result = lo_r;
    else                      result = {N{1'b0}};
  end

  assign stall       = start & busy_r & is_sup_s;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;
  assign hi          = hi_r;
  assign lo          = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed vectors push expectations, a monitor checks each done.
module tb_mult_div_unit;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [5:0]  funct;
  logic [31:0] rs_data, rt_data, result, hi, lo;
  logic        busy, done, stall, div_by_zero;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   failed = 0;
  int   lat;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .rs_data(rs_data), .rt_data(rt_data), .result(result),
    .busy(busy), .done(done), .stall(stall), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = d;
    return e;
  endfunction

  // Called #1 after a rising edge; that edge's successor is edge 0 (the start edge).
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct = f; rs_data = a; rt_data = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int e0, output int l);
    l = -1;
    for (int e = e0; e < e0 + 80; e++) begin
      @(negedge clk);
      if (done) begin
        l = e;
        break;
      end
    end
  endtask

  task automatic run(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int l;
    exp_q.push_back(mk(eh, el, ed));
    issue(f, a, b);
    wait_done(0, l);
    check("latency", l, 34);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, expected no done", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_by_zero", div_by_zero, mon_e.dbz);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; funct = 6'd0; rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // MULT -3*5 with cycle-exact busy/done profile
    exp_q.push_back(mk(32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0));
    issue(F_MULT, 32'hFFFFFFFD, 32'h00000005);
    for (int e = 0; e <= 35; e++) begin
      @(negedge clk);
      check("busy_timing", busy, (e <= 33));
      check("done_timing", done, (e == 34));
      @(posedge clk); #1;
    end
    funct = F_MFLO; #1;
    check("result_mflo", result, 32'hFFFFFFF1);
    funct = F_MFHI; #1;
    check("result_mfhi", result, 32'hFFFFFFFF);
    funct = F_MULT; #1;
    check("result_other", result, 0);
    @(posedge clk); #1;

    run(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run(F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run(F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    run(F_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("dbz_sticky", div_by_zero, 1);
    @(posedge clk); #1;
    exp_q.push_back(mk(32'h00000000, 32'h0000000C, 1'b0));
    issue(F_MULTU, 32'h00000003, 32'h00000004);
    @(negedge clk);
    check("dbz_cleared_on_accept", div_by_zero, 0);
    wait_done(1, lat);
    check("latency", lat, 34);
    @(posedge clk); #1;

    run(F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run(F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    run(F_DIV,  32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);

    // Starts while busy are stalled and ignored
    exp_q.push_back(mk(32'h00000000, 32'h0000002A, 1'b0));
    issue(F_MULT, 32'h00000006, 32'h00000007);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; funct = F_MFLO; rs_data = 32'd0; rt_data = 32'd0;
    @(negedge clk);
    check("stall_mflo", stall, 1);
    @(posedge clk); #1;
    funct = F_MULTU; rs_data = 32'hFFFFFFFF; rt_data = 32'hFFFFFFFF;
    @(negedge clk);
    check("stall_multu", stall, 1);
    check("busy_during_stall", busy, 1);
    @(posedge clk); #1;
    funct = F_ADD;
    @(negedge clk);
    check("stall_unsupported", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(7, lat);
    check("latency_stalled_op", lat, 34);
    @(posedge clk); #1;

    // Unsupported funct in idle is ignored
    issue(F_ADD, 32'h00000005, 32'h00000009);
    @(negedge clk);
    check("unsup_busy", busy, 0);
    check("unsup_lo", lo, 32'h0000002A);
    check("unsup_hi", hi, 32'h00000000);
    @(posedge clk); #1;

    // Moves to and from HI/LO
    issue(F_MTHI, 32'h12345678, 32'h0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", busy, 0);
    @(posedge clk); #1;
    issue(F_MTLO, 32'h9ABCDEF0, 32'h0);
    @(negedge clk);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtlo_done", done, 0);
    funct = F_MFHI; #1;
    check("mfhi_result", result, 32'h12345678);
    funct = F_MFLO; #1;
    check("mflo_result", result, 32'h9ABCDEF0);
    @(posedge clk); #1;

    // Reset in the middle of a divide
    issue(F_DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (40) @(posedge clk);
    #1;
    issue(F_MTLO, 32'h000000A5, 32'h0);
    @(negedge clk);
    check("post_reset_mtlo", lo, 32'h000000A5);
    check("post_reset_hi", hi, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_no_done", done, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
